// File: rtl/layer_stream_tx.sv
// Captures one layer's parallel activations on a strobe and replays them as a
// contiguous serial frame, with one pending-frame buffer and a forced idle gap.
module layer_stream_tx #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16,
  parameter int frameGap  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] x_in,
  input  logic                           x_valid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overrun,
  input  logic                           overrun_clr
);

  localparam int IW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(numNeuron - 1);
  localparam logic [7:0]    GAP_LOAD = 8'(frameGap - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [7:0]                     gcnt_q, gcnt_d;
  logic [numNeuron*dataWidth-1:0] active_q, active_d;
  logic [numNeuron*dataWidth-1:0] pending_q, pending_d;
  logic                           pend_v_q, pend_v_d;
  logic [dataWidth-1:0]           out_data_q, out_data_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_last_q, out_last_d;
  logic                           busy_q, busy_d;
  logic                           overrun_q, overrun_d;
  logic                           dropEvt;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gcnt_d      = gcnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_v_d    = pend_v_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    dropEvt     = 1'b0;

    case (state_q)
      IDLE: begin
        if (x_valid) begin
          active_d = x_in;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end

      STREAM: begin
        out_data_d  = active_q[idx_q*dataWidth +: dataWidth];
        out_valid_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          out_last_d = 1'b1;
          gcnt_d     = GAP_LOAD;
          idx_d      = '0;
          state_d    = GAP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (x_valid) begin
          if (!pend_v_q) begin
            pending_d = x_in;
            pend_v_d  = 1'b1;
          end else begin
            dropEvt = 1'b1;
          end
        end
      end

      GAP: begin
        if (gcnt_q == 8'd0) begin
          idx_d = '0;
          // Promotion frees the pending slot, so a same-cycle strobe refills it.
          if (pend_v_q) begin
            active_d = pending_q;
            pend_v_d = 1'b0;
            state_d  = STREAM;
            if (x_valid) begin
              pending_d = x_in;
              pend_v_d  = 1'b1;
            end
          end else if (x_valid) begin
            active_d = x_in;
            state_d  = STREAM;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gcnt_d = gcnt_q - 8'd1;
          if (x_valid) begin
            if (!pend_v_q) begin
              pending_d = x_in;
              pend_v_d  = 1'b1;
            end else begin
              dropEvt = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    overrun_d = dropEvt ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    busy_d    = (state_d != IDLE) || pend_v_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gcnt_q      <= 8'd0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_v_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gcnt_q      <= gcnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_v_q    <= pend_v_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_layer_stream_tx.sv
// Scoreboard bench for layer_stream_tx: a frame-level timing model predicts
// each beat's cycle, data and last flag, plus busy and the sticky overrun.
module tb_layer_stream_tx;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int G  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] x_in = '0;
  logic            x_valid = 1'b0;
  logic            overrun_clr = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic            busy;
  logic            overrun;

  layer_stream_tx #(.numNeuron(N), .dataWidth(DW), .frameGap(G)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cycle;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb[$];
  beat_t mb;
  int    total = 0;
  int    bad = 0;
  int    lastStart = -100;
  logic  expOverrun = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a frame starts once the previous frame plus gap is done,
  // and is dropped if an earlier accepted frame still waits to be promoted.
  task automatic applyStimulus(input logic xv, input logic [N*DW-1:0] xin, input logic clr);
    int u;
    int start;
    @(negedge clk);
    #2;
    x_valid     = xv;
    x_in        = xin;
    overrun_clr = clr;
    u = cyc + 1;
    if (xv && (lastStart - 1 > u)) begin
      expOverrun = 1'b1;
    end else begin
      if (clr) expOverrun = 1'b0;
      if (xv) begin
        start = (u + 1 > lastStart + N + G) ? u + 1 : lastStart + N + G;
        for (int i = 0; i < N; i++) begin
          sb.push_back('{cycle: start + i, data: xin[i*DW +: DW], last: (i == N - 1)});
        end
        lastStart = start;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
  endtask

  task automatic midReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    x_valid = 1'b0;
    overrun_clr = 1'b0;
    #1;
    checkResetOutputs();
    sb.delete();
    lastStart = -100;
    expOverrun = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Monitor: every cycle compares busy/overrun and consumes beats from the queue.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("busy", 32'(busy), 32'(cyc < lastStart + N + G - 1));
      checkOutput("overrun", 32'(overrun), 32'(expOverrun));
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h with no frame expected (cycle %0d)", out_data, cyc);
        end else begin
          mb = sb.pop_front();
          checkOutput("beat_cycle", 32'(cyc), 32'(mb.cycle));
          checkOutput("beat_data", 32'(out_data), 32'(mb.data));
          checkOutput("beat_last", 32'(out_last), 32'(mb.last));
        end
      end else begin
        checkOutput("last_idle", 32'(out_last), 32'd0);
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    #1 checkResetOutputs();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    idle(5);

    $display("[TB] single frame");
    applyStimulus(1'b1, pack(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b0);
    idle(12);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, pack(16'h0011, 16'h0012, 16'h0013, 16'h0014), 1'b0);
    idle(1);
    applyStimulus(1'b1, pack(16'h0021, 16'h0022, 16'h0023, 16'h0024), 1'b0);
    idle(16);

    $display("[TB] overrun and clear");
    applyStimulus(1'b1, pack(16'h0101, 16'h0102, 16'h0103, 16'h0104), 1'b0);
    applyStimulus(1'b1, pack(16'h0201, 16'h0202, 16'h0203, 16'h0204), 1'b0);
    applyStimulus(1'b1, pack(16'h0301, 16'h0302, 16'h0303, 16'h0304), 1'b0);
    idle(16);
    applyStimulus(1'b0, '0, 1'b1);
    idle(3);

    $display("[TB] overrun set beats same-cycle clear");
    applyStimulus(1'b1, pack(16'h0401, 16'h0402, 16'h0403, 16'h0404), 1'b0);
    applyStimulus(1'b1, pack(16'h0501, 16'h0502, 16'h0503, 16'h0504), 1'b0);
    applyStimulus(1'b1, pack(16'h0601, 16'h0602, 16'h0603, 16'h0604), 1'b1);
    idle(16);
    applyStimulus(1'b0, '0, 1'b1);
    idle(3);

    $display("[TB] strobe on final gap cycle, nothing pending");
    applyStimulus(1'b1, pack(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04), 1'b0);
    idle(N + G - 1);
    applyStimulus(1'b1, pack(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04), 1'b0);
    idle(16);

    $display("[TB] strobe on final gap cycle with a pending frame");
    applyStimulus(1'b1, pack(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04), 1'b0);
    idle(1);
    applyStimulus(1'b1, pack(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04), 1'b0);
    idle(N + G - 3);
    applyStimulus(1'b1, pack(16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04), 1'b0);
    idle(24);

    $display("[TB] mid-frame reset");
    applyStimulus(1'b1, pack(16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04), 1'b0);
    idle(2);
    midReset();
    idle(15);

    $display("[TB] signed data");
    applyStimulus(1'b1, pack(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000), 1'b0);
    idle(12);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom_range(0, 15) == 0);
    end
    idle(30);

    checkOutput("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
